ita_activation_collector: RTL and testbench

Receive-side companion of the activation stage. It tracks words launched into the fixed-latency, non-stallable activation pipeline, captures their outputs when they emerge, and buffers them in a small FIFO. The FIFO is drained to the output writer with a valid/ready handshake. Upstream is throttled by credits, so backpressure from the output writer never causes activation results to be lost.

---
 rtl/ita_activation_collector.sv | 171 +++++++++++++++++
 tb/tb_ita_activation_collector.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ita_activation_collector.sv
`default_nettype none
// ============================================================================
// Module   : ita_activation_collector
// Purpose  : Receive-side companion of the activation stage. Tracks words
//            launched into the fixed-latency, non-stallable activation
//            pipeline, captures the pipeline output when it emerges and
//            buffers it in a small circular FIFO that drains to the output
//            writer over a valid/ready handshake. Upstream issue is throttled
//            by credits (FIFO occupancy + words in flight) so backpressure
//            from the writer never loses a result.
// Ports    : clk_i, rst_ni (async, active-low), flush_i (sync clear)
//            issue_i / issue_last_i / issue_ready_o : upstream issue + credit
//            act_data_i    : activation stage output, lane i at [i*WO +: WO]
//            oup_valid_o / oup_ready_i / oup_data_o / oup_last_o : FIFO head
//            busy_o        : any word in flight or buffered
//            overflow_o    : sticky, a word arrived while the FIFO was full
//            stall_cnt_o   : (ITA_ACT_COLLECT_STATS_EN only) cycles with a
//                            valid head and no ready, saturating
// Options  : define ITA_ACT_COLLECT_STATS_EN to add stall_cnt_o.
// Revision : 1.0 - initial release
// ============================================================================
module ita_activation_collector #(
  parameter int N       = 16,
  parameter int WO      = 8,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            issue_i,
  input  logic            issue_last_i,
  output logic            issue_ready_o,
  input  logic [N*WO-1:0] act_data_i,
  output logic            oup_valid_o,
  input  logic            oup_ready_i,
  output logic [N*WO-1:0] oup_data_o,
  output logic            oup_last_o,
  output logic            busy_o,
  output logic            overflow_o
`ifdef ITA_ACT_COLLECT_STATS_EN
  ,
  output logic [31:0]     stall_cnt_o
`endif
);

  localparam int unsigned c_ptr_w       = $clog2(DEPTH) + 1;
  // Storage index width; rounded up so a pointer slice indexes the array exactly.
  localparam int unsigned c_addr_w      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned c_mem_entries = 1 << c_addr_w;
  // Wide enough to hold count + inflight without wrapping.
  localparam int unsigned c_sum_w       = c_ptr_w + $clog2(LATENCY + 1) + 1;

  // Delay line mirroring the activation pipeline.
  logic [LATENCY-1:0] r_dl_valid;
  logic [LATENCY-1:0] r_dl_last;

  // FIFO state.
  logic [N*WO-1:0]        r_mem_data [c_mem_entries];
  logic [c_mem_entries-1:0] r_mem_last;
  logic [c_ptr_w-1:0]     r_wr_ptr;
  logic [c_ptr_w-1:0]     r_rd_ptr;
  logic [c_ptr_w-1:0]     r_count;
  logic                   r_overflow;

  logic [c_sum_w-1:0]     w_inflight;
  logic                   w_issue;
  logic                   w_push_req;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;

  function automatic logic [c_ptr_w-1:0] f_next_ptr(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
  endfunction

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      w_inflight = w_inflight + c_sum_w'(r_dl_valid[i]);
    end
  end

  // Credits count words already committed to the FIFO plus those still in
  // the pipeline; a pop only frees a credit once r_count has dropped.
  assign issue_ready_o = (c_sum_w'(r_count) + w_inflight) < c_sum_w'(DEPTH);
  assign w_issue       = issue_i & issue_ready_o;

  assign w_push_req    = r_dl_valid[LATENCY-1];
  assign w_full        = (r_count == c_ptr_w'(DEPTH));
  assign w_push        = w_push_req & ~w_full;
  assign oup_valid_o   = (r_count != '0);
  assign w_pop         = oup_valid_o & oup_ready_i;

  assign oup_data_o    = r_mem_data[r_rd_ptr[c_addr_w-1:0]];
  assign oup_last_o    = r_mem_last[r_rd_ptr[c_addr_w-1:0]];
  assign busy_o        = oup_valid_o | (w_inflight != '0);
  assign overflow_o    = r_overflow;

  // Delay line: stage 0 loads the accepted issue, later stages shift.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_dl_valid <= '0;
      r_dl_last  <= '0;
    end else if (flush_i) begin
      r_dl_valid <= '0;
    end else begin
      r_dl_valid[0] <= w_issue;
      r_dl_last[0]  <= issue_last_i;
      for (int i = 1; i < LATENCY; i++) begin
        r_dl_valid[i] <= r_dl_valid[i-1];
        r_dl_last[i]  <= r_dl_last[i-1];
      end
    end
  end

  // FIFO. The capture path has no enable: a word in the last stage is
  // written this cycle, or dropped (and flagged) if the FIFO is full.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_mem_last <= '0;
      for (int i = 0; i < int'(c_mem_entries); i++) begin
        r_mem_data[i] <= '0;
      end
    end else if (flush_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr[c_addr_w-1:0]] <= act_data_i;
        r_mem_last[r_wr_ptr[c_addr_w-1:0]] <= r_dl_last[LATENCY-1];
        r_wr_ptr <= f_next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_next_ptr(r_rd_ptr);
      end
      if (w_push & ~w_pop) begin
        r_count <= r_count + c_ptr_w'(1);
      end else if (~w_push & w_pop) begin
        r_count <= r_count - c_ptr_w'(1);
      end
      if (w_push_req & w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef ITA_ACT_COLLECT_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (flush_i) begin
      r_stall_cnt <= '0;
    end else if (oup_valid_o & ~oup_ready_i & (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ita_activation_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_ita_activation_collector
// Purpose  : Self-checking bench for ita_activation_collector. Drives the
//            activation pipeline output itself, tracks expected FIFO contents
//            with queue-based bookkeeping and compares every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ita_activation_collector;

  localparam int N     = 16;
  localparam int WO    = 8;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int W     = N * WO;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         flush_i = 1'b0;
  logic         issue_i = 1'b0;
  logic         issue_last_i = 1'b0;
  logic         issue_ready_o;
  logic [W-1:0] act_data_i = '0;
  logic         oup_valid_o;
  logic         oup_ready_i = 1'b0;
  logic [W-1:0] oup_data_o;
  logic         oup_last_o;
  logic         busy_o;
  logic         overflow_o;
`ifdef ITA_ACT_COLLECT_STATS_EN
  logic [31:0]  stall_cnt_o;
`endif

  ita_activation_collector #(
    .N(N), .WO(WO), .LATENCY(LAT), .DEPTH(DEPTH)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .issue_i      (issue_i),
    .issue_last_i (issue_last_i),
    .issue_ready_o(issue_ready_o),
    .act_data_i   (act_data_i),
    .oup_valid_o  (oup_valid_o),
    .oup_ready_i  (oup_ready_i),
    .oup_data_o   (oup_data_o),
    .oup_last_o   (oup_last_o),
    .busy_o       (busy_o),
    .overflow_o   (overflow_o)
`ifdef ITA_ACT_COLLECT_STATS_EN
    ,
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Reference model: words travelling through the pipeline (with the cycle
  // in which they reach the activation output) and words held in the FIFO.
  typedef struct { logic [W-1:0] data; logic last; int arrive; } fl_t;
  typedef struct { logic [W-1:0] data; logic last; } ent_t;
  fl_t         inq[$];
  ent_t        mq[$];
  logic        m_ovf = 1'b0;
  longint      m_stall = 0;

  typedef struct {
    logic iss; logic isl; logic rdy; logic fl;
    logic e_rdy; logic e_val; logic e_busy; logic e_ovf;
  } vec_t;
  vec_t tbl[23];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Called #1 after a rising edge: drive one cycle of inputs, check the
  // outputs against the model, then advance through the next edge.
  task automatic cyc_step(input logic iss, input logic isl, input logic [W-1:0] d,
                          input logic rdy, input logic fl);
    logic exp_rdy, exp_val, was_full;
    int   infl;
    fl_t  f;
    issue_i      = iss;
    issue_last_i = isl;
    oup_ready_i  = rdy;
    flush_i      = fl;
    if (inq.size() > 0 && inq[0].arrive == cyc) act_data_i = inq[0].data;
    else act_data_i = rnd_word();
    infl    = inq.size();
    exp_rdy = (mq.size() + infl) < DEPTH;
    exp_val = mq.size() != 0;
    chk("issue_ready", W'(issue_ready_o), W'(exp_rdy));
    chk("oup_valid", W'(oup_valid_o), W'(exp_val));
    chk("busy", W'(busy_o), W'(mq.size() != 0 || infl != 0));
    chk("overflow", W'(overflow_o), W'(m_ovf));
    if (exp_val) begin
      chk("oup_data", oup_data_o, mq[0].data);
      chk("oup_last", W'(oup_last_o), W'(mq[0].last));
    end
`ifdef ITA_ACT_COLLECT_STATS_EN
    chk("stall_cnt", W'(stall_cnt_o), W'(m_stall));
`endif
    @(posedge clk_i);
    #1;
    if (fl) begin
      inq.delete();
      mq.delete();
      m_ovf   = 1'b0;
      m_stall = 0;
    end else begin
      if (exp_val && !rdy && m_stall < 64'hFFFF_FFFF) m_stall++;
      was_full = (mq.size() == DEPTH);
      if (exp_val && rdy) void'(mq.pop_front());
      if (inq.size() > 0 && inq[0].arrive == cyc) begin
        f = inq.pop_front();
        if (!was_full) mq.push_back('{data: f.data, last: f.last});
        else m_ovf = 1'b1;
      end
      if (iss && exp_rdy) inq.push_back('{data: d, last: isl, arrive: cyc + LAT});
    end
    cyc++;
  endtask

  function automatic vec_t mk(input logic iss, input logic isl, input logic rdy, input logic fl,
                              input logic er, input logic ev, input logic eb, input logic eo);
    vec_t v;
    v.iss = iss; v.isl = isl; v.rdy = rdy; v.fl = fl;
    v.e_rdy = er; v.e_val = ev; v.e_busy = eb; v.e_ovf = eo;
    return v;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [W-1:0] lanes;
    for (int i = 0; i < N; i++) lanes[i*WO +: WO] = WO'(i + 1);

    // Single word issued at row 5, then backpressure with continuous issue.
    for (int i = 0; i < 5; i++) tbl[i] = mk(0, 0, 1, 0, 1, 0, 0, 0);
    tbl[5]  = mk(1, 1, 1, 0, 1, 0, 0, 0);
    tbl[6]  = mk(0, 0, 1, 0, 1, 0, 1, 0);
    tbl[7]  = mk(0, 0, 1, 0, 1, 0, 1, 0);
    tbl[8]  = mk(0, 0, 1, 0, 1, 1, 1, 0);
    tbl[9]  = mk(0, 0, 1, 0, 1, 0, 0, 0);
    tbl[10] = mk(0, 0, 1, 0, 1, 0, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 1, 0, 0, 0);
    tbl[12] = mk(1, 0, 0, 0, 1, 0, 1, 0);
    tbl[13] = mk(1, 0, 0, 0, 1, 0, 1, 0);
    tbl[14] = mk(1, 0, 0, 0, 1, 1, 1, 0);
    for (int i = 15; i < 19; i++) tbl[i] = mk(1, 0, 0, 0, 0, 1, 1, 0);
    tbl[19] = mk(1, 0, 1, 0, 0, 1, 1, 0);   // issue ignored, one pop
    tbl[20] = mk(0, 0, 0, 0, 1, 1, 1, 0);   // freed credit visible
    tbl[21] = mk(1, 0, 0, 0, 1, 1, 1, 0);   // credit consumed again
    tbl[22] = mk(0, 0, 0, 0, 0, 1, 1, 0);

    // Reset state.
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_issue_ready", W'(issue_ready_o), W'(1'b1));
    chk("rst_valid", W'(oup_valid_o), '0);
    chk("rst_data", oup_data_o, '0);
    chk("rst_last", W'(oup_last_o), '0);
    chk("rst_busy", W'(busy_o), '0);
    chk("rst_overflow", W'(overflow_o), '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Table-driven single word and backpressure.
    for (int i = 0; i < 23; i++) begin
      chk("tbl_issue_ready", W'(issue_ready_o), W'(tbl[i].e_rdy));
      chk("tbl_valid", W'(oup_valid_o), W'(tbl[i].e_val));
      chk("tbl_busy", W'(busy_o), W'(tbl[i].e_busy));
      chk("tbl_overflow", W'(overflow_o), W'(tbl[i].e_ovf));
      if (i == 8) begin
        chk("single_data", oup_data_o, lanes);
        chk("single_last", W'(oup_last_o), W'(1'b1));
      end
      cyc_step(tbl[i].iss, tbl[i].isl, (i < 11) ? lanes : rnd_word(), tbl[i].rdy, tbl[i].fl);
    end

    // FIFO fills to DEPTH; then inject an arrival while full.
    cyc_step(0, 0, '0, 0, 0);
    cyc_step(0, 0, '0, 0, 0);
    chk("full_before_ovf", W'(mq.size() == DEPTH && oup_valid_o && !issue_ready_o), W'(1'b1));
    issue_i = 1'b0; oup_ready_i = 1'b0; flush_i = 1'b0;
    act_data_i = rnd_word();
    force dut.r_dl_valid = 2'b10;
    @(posedge clk_i);
    #1;
    release dut.r_dl_valid;
    cyc++;
    m_ovf = 1'b1;
    chk("ovf_next_cycle", W'(overflow_o), W'(1'b1));
    cyc_step(0, 0, '0, 0, 0);
    cyc_step(0, 0, '0, 0, 0);
    cyc_step(0, 0, '0, 1, 0);             // contents unchanged: model pops
    cyc_step(0, 0, '0, 1, 0);
    cyc_step(0, 0, '0, 0, 1);             // flush with two words left
    chk("flush_ovf_clear", W'(overflow_o), '0);
    chk("flush_count_zero", W'(oup_valid_o), '0);

    // Flush with words in flight (and an issue in the flush cycle).
    cyc_step(1, 0, rnd_word(), 1, 0);
    cyc_step(1, 1, rnd_word(), 1, 0);
    cyc_step(1, 0, rnd_word(), 1, 1);
    chk("flush_inflight_ready", W'(issue_ready_o), W'(1'b1));
    for (int i = 0; i < 6; i++) cyc_step(0, 0, '0, 1, 0);

    // Streaming: 64 back-to-back issues with ready held high.
    for (int i = 0; i < 64; i++) cyc_step(1, 1'(i % 8 == 7), rnd_word(), 1, 0);
    for (int i = 0; i < 5; i++) cyc_step(0, 0, '0, 1, 0);

`ifdef ITA_ACT_COLLECT_STATS_EN
    cyc_step(0, 0, '0, 1, 1);
    cyc_step(1, 1, rnd_word(), 0, 0);
    for (int i = 0; i < 12; i++) cyc_step(0, 0, '0, 0, 0);
    chk("stall_cnt_10", W'(stall_cnt_o), W'(32'd10));
    cyc_step(0, 0, '0, 0, 1);
    chk("stall_cnt_flush", W'(stall_cnt_o), '0);
`endif

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cyc_step(1'($urandom_range(0, 3) != 0), 1'($urandom), rnd_word(),
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) == 0));
    end

    // Asynchronous reset with traffic in flight.
    cyc_step(1, 0, rnd_word(), 0, 0);
    cyc_step(1, 0, rnd_word(), 0, 0);
    cyc_step(1, 0, rnd_word(), 0, 0);
    rst_ni = 1'b0;
    #2;
    chk("arst_valid", W'(oup_valid_o), '0);
    chk("arst_busy", W'(busy_o), '0);
    chk("arst_ready", W'(issue_ready_o), W'(1'b1));
    chk("arst_data", oup_data_o, '0);
    inq.delete(); mq.delete(); m_ovf = 1'b0; m_stall = 0;
    issue_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) cyc_step(0, 0, '0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
